// File: rtl/robot_controller.sv
// robot_controller: wall-following maze robot FSM with rubble clearing and trap detection.
// Latency: sensors sampled every posedge clk; motion outputs decode from the state register one cycle later.
// Backpressure: none; the robot issues one action per cycle, and TRAPPED halts it until reset.
//
// Ports:
//   clk        - divided clock, all logic on its rising edge
//   reset      - synchronous, active-high; returns to IDLE and clears all saved context
//   head       - 1 = wall directly ahead
//   left       - 1 = wall on the left side
//   under      - 1 = rubble in the current cell (highest priority while moving)
//   advance    - move forward one cell (SEARCH, FOLLOW)
//   turn_right - rotate clockwise (ROT_R)
//   turn_left  - rotate counter-clockwise (TURN_L)
//   remove     - clear rubble (REMOVE)
//   trapped    - robot halted, no progress possible (TRAPPED)
//   state      - current state code, debug only
module robot_controller #(
  parameter int unsigned max_turns = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       head,
  input  logic       left,
  input  logic       under,
  output logic       advance,
  output logic       turn_right,
  output logic       turn_left,
  output logic       remove,
  output logic       trapped,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_SEARCH  = 3'b001,
    S_FOLLOW  = 3'b010,
    S_ROT_R   = 3'b011,
    S_TURN_L  = 3'b100,
    S_REMOVE  = 3'b101,
    S_TRAPPED = 3'b110
  } state_t;

  // Counter value at which one more blocked right turn means the robot is boxed in.
  localparam logic [2:0] TRAP_CNT = 3'(max_turns - 1);

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;   // where to resume once rubble is cleared
  logic [2:0] cnt_q, cnt_d;   // number of ROT_R cycles already repeated in this rotation run

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_SEARCH;
      end

      S_SEARCH: begin
        if (under) begin
          state_d = S_REMOVE;
          ret_d   = S_SEARCH;
        end else if (left) begin
          state_d = S_FOLLOW;
        end else if (head) begin
          state_d = S_ROT_R;
        end
      end

      S_FOLLOW: begin
        if (under) begin
          state_d = S_REMOVE;
          ret_d   = S_FOLLOW;
        end else if (!left) begin
          state_d = S_TURN_L;
        end else if (head) begin
          state_d = S_ROT_R;
        end
      end

      S_TURN_L: begin
        if (under) begin
          state_d = S_REMOVE;
          ret_d   = S_TURN_L;
        end else begin
          state_d = S_SEARCH;
        end
      end

      S_ROT_R: begin
        if (under) begin
          // Rubble interrupts the rotation; the count is kept so the
          // remaining turn budget survives the detour.
          state_d = S_REMOVE;
          ret_d   = S_ROT_R;
        end else if (!head) begin
          state_d = left ? S_FOLLOW : S_SEARCH;
        end else if (cnt_q == TRAP_CNT) begin
          state_d = S_TRAPPED;
        end else begin
          state_d = S_ROT_R;
          cnt_d   = cnt_q + 3'd1;
        end
      end

      S_REMOVE: begin
        if (!under) begin
          state_d = ret_q;
        end
      end

      S_TRAPPED: begin
        state_d = S_TRAPPED;
      end

      default: begin
        // Unused code 111 recovers to IDLE.
        state_d = S_IDLE;
      end
    endcase

    // Any forward-moving state starts a fresh rotation budget.
    if (state_d == S_SEARCH || state_d == S_FOLLOW) begin
      cnt_d = 3'd0;
    end
  end

  always_comb begin
    advance    = 1'b0;
    turn_right = 1'b0;
    turn_left  = 1'b0;
    remove     = 1'b0;
    trapped    = 1'b0;
    case (state_q)
      S_SEARCH,
      S_FOLLOW:  advance    = 1'b1;
      S_ROT_R:   turn_right = 1'b1;
      S_TURN_L:  turn_left  = 1'b1;
      S_REMOVE:  remove     = 1'b1;
      S_TRAPPED: trapped    = 1'b1;
      default:   ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_robot_controller.sv
// tb_robot_controller: directed scenario tables plus randomized run against a behavioural model.
module tb_robot_controller;

  localparam int MAX_TURNS = 4;

  // State codes visible on the debug port.
  localparam int M_IDLE    = 0;
  localparam int M_SEARCH  = 1;
  localparam int M_FOLLOW  = 2;
  localparam int M_ROT_R   = 3;
  localparam int M_TURN_L  = 4;
  localparam int M_REMOVE  = 5;
  localparam int M_TRAPPED = 6;

  logic       clk;
  logic       reset;
  logic       head;
  logic       left;
  logic       under;
  logic       advance;
  logic       turn_right;
  logic       turn_left;
  logic       remove;
  logic       trapped;
  logic [2:0] state;

  logic [7:0] dut_vec;
  assign dut_vec = {state, advance, turn_right, turn_left, remove, trapped};

  int tests    = 0;
  int failures = 0;

  // Behavioural model: current behaviour, behaviour to resume after rubble,
  // and how many right turns remain before the robot gives up.
  int m_mode   = M_IDLE;
  int m_resume = M_IDLE;
  int m_budget = MAX_TURNS;

  robot_controller #(.max_turns(MAX_TURNS)) dut (
    .clk       (clk),
    .reset     (reset),
    .head      (head),
    .left      (left),
    .under     (under),
    .advance   (advance),
    .turn_right(turn_right),
    .turn_left (turn_left),
    .remove    (remove),
    .trapped   (trapped),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected debug code plus action outputs for a given state code.
  function automatic logic [7:0] exp_out(input logic [2:0] code);
    logic [4:0] o;
    o = 5'b00000;
    case (code)
      3'b001, 3'b010: o = 5'b10000;
      3'b011:         o = 5'b01000;
      3'b100:         o = 5'b00100;
      3'b101:         o = 5'b00010;
      3'b110:         o = 5'b00001;
      default:        o = 5'b00000;
    endcase
    return {code, o};
  endfunction

  task automatic model_tick(input bit r, input bit h, input bit l, input bit u);
    if (r) begin
      m_mode   = M_IDLE;
      m_resume = M_IDLE;
      m_budget = MAX_TURNS;
    end else if (u && (m_mode == M_SEARCH || m_mode == M_FOLLOW ||
                       m_mode == M_ROT_R  || m_mode == M_TURN_L)) begin
      m_resume = m_mode;
      m_mode   = M_REMOVE;
    end else begin
      case (m_mode)
        M_IDLE:   m_mode = M_SEARCH;
        M_SEARCH: begin
          if (l) m_mode = M_FOLLOW;
          else if (h) begin m_mode = M_ROT_R; m_budget = MAX_TURNS; end
        end
        M_FOLLOW: begin
          if (!l) m_mode = M_TURN_L;
          else if (h) begin m_mode = M_ROT_R; m_budget = MAX_TURNS; end
        end
        M_TURN_L: m_mode = M_SEARCH;
        M_ROT_R: begin
          if (!h) m_mode = l ? M_FOLLOW : M_SEARCH;
          else if (m_budget == 1) m_mode = M_TRAPPED;
          else m_budget = m_budget - 1;
        end
        M_REMOVE: if (!u) m_mode = m_resume;
        M_TRAPPED: m_mode = M_TRAPPED;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Apply one cycle of inputs, clock it, and sample 1 time unit after the edge.
  task automatic tick(input bit r, input bit h, input bit l, input bit u);
    reset = r;
    head  = h;
    left  = l;
    under = u;
    @(posedge clk);
    model_tick(r, h, l, u);
    #1;
  endtask

  // Table entries: {reset, head, left, under, expected_state[2:0]}
  task automatic test_reset();
    logic [6:0] tbl [4] = '{7'b1000_000, 7'b1111_000, 7'b0111_001, 7'b1000_000};
    for (int i = 0; i < 4; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL reset step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
  endtask

  task automatic test_open_field();
    logic [6:0] tbl [6] = '{7'b1000_000, 7'b0000_001, 7'b0000_001,
                            7'b0000_001, 7'b0000_001, 7'b0000_001};
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL open_field step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
  endtask

  task automatic test_wall_follow();
    logic [6:0] tbl [6] = '{7'b1000_000, 7'b0000_001, 7'b0010_010,
                            7'b0110_011, 7'b0010_010, 7'b0010_010};
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL wall_follow step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
  endtask

  task automatic test_trap();
    logic [6:0] tbl [12] = '{7'b1000_000, 7'b0000_001, 7'b0010_010,
                             7'b0110_011, 7'b0110_011, 7'b0110_011, 7'b0110_011,
                             7'b0110_110, 7'b0111_110, 7'b0001_110, 7'b0000_110,
                             7'b0100_110};
    int n_right;
    n_right = 0;
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      if (turn_right) n_right++;
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL trap step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
    tests++;
    if (n_right !== MAX_TURNS) begin
      failures++;
      $display("FAIL trap_turn_count: got %0d turn_right cycles want %0d", n_right, MAX_TURNS);
    end
  endtask

  task automatic test_rubble();
    logic [6:0] tbl [14] = '{7'b1000_000, 7'b0000_001, 7'b0010_010,
                             7'b0011_101, 7'b0011_101, 7'b0010_010, 7'b0010_010,
                             7'b0110_011, 7'b0110_011, 7'b0110_011,
                             7'b0111_101, 7'b0110_011, 7'b0110_011, 7'b0110_110};
    int n_remove;
    n_remove = 0;
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      if (i < 7 && remove) n_remove++;
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL rubble step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
    tests++;
    if (n_remove !== 2) begin
      failures++;
      $display("FAIL rubble_remove_count: got %0d remove cycles want 2", n_remove);
    end
  endtask

  task automatic test_lost_wall();
    logic [6:0] tbl [6] = '{7'b1000_000, 7'b0000_001, 7'b0010_010,
                            7'b0000_100, 7'b0110_001, 7'b0000_001};
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL lost_wall step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] tbl [15] = '{7'b1000_000, 7'b0000_001, 7'b0001_101, 7'b0001_101,
                             7'b1001_000, 7'b0000_001, 7'b0000_001,
                             7'b0100_011, 7'b0100_011, 7'b0100_011, 7'b0100_011,
                             7'b0100_110, 7'b1000_000, 7'b0100_001, 7'b0000_001};
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i][6], tbl[i][5], tbl[i][4], tbl[i][3]);
      tests++;
      if (dut_vec !== exp_out(tbl[i][2:0])) begin
        failures++;
        $display("FAIL reset_mid step %0d: got %b want %b", i, dut_vec, exp_out(tbl[i][2:0]));
      end
    end
  endtask

  task automatic test_random();
    bit r, h, l, u;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if (m_mode == M_TRAPPED) r = ($urandom_range(0, 5) == 0);
      else                     r = ($urandom_range(0, 79) == 0);
      h = ($urandom_range(0, 99) < 55);
      l = ($urandom_range(0, 1) == 1);
      u = ($urandom_range(0, 7) == 0);
      tick(r, h, l, u);
      tests++;
      if (dut_vec !== exp_out(3'(m_mode))) begin
        failures++;
        $display("FAIL random cycle %0d: got %b want %b (r=%0b h=%0b l=%0b u=%0b)",
                 i, dut_vec, exp_out(3'(m_mode)), r, h, l, u);
      end
      tests++;
      if ($countones({advance, turn_right, turn_left, remove}) > 1) begin
        failures++;
        $display("FAIL random_onehot cycle %0d: got motion %b want at most one bit set",
                 i, {advance, turn_right, turn_left, remove});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    head  = 1'b0;
    left  = 1'b0;
    under = 1'b0;
    test_reset();
    test_open_field();
    test_wall_follow();
    test_trap();
    test_rubble();
    test_lost_wall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
